// File: rtl/bp_pkg.sv
// Types and helpers shared between branch_predictor and the in-flight branch tracker.
package bp_pkg;

   localparam int GH_DEFAULT = 4;
   localparam int GHR_MAX    = 32;

   // The GHR snapshot lives beside this struct because its width follows the GH parameter.
   typedef struct packed {
      logic        valid;
      logic        resolved;
      logic        mispredicted;
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic        act_taken;
      logic [31:0] act_target;
   } inflight_entry_t;

   // Shift one outcome into a history vector; callers narrow the result to their GH.
   function automatic logic [GHR_MAX-1:0] ghr_push(input logic [GHR_MAX-1:0] snap,
                                                   input logic               taken);
      return (snap << 1) | GHR_MAX'(taken);
   endfunction

endpackage

// File: rtl/inflight_ring_ptr.sv
// Head/tail/occupancy bookkeeping for the in-flight ring, including truncation back to a tag.
module inflight_ring_ptr #(
   parameter  int DEPTH    = 8,
   localparam int TAG_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                alloc,
   input  logic                retire,
   input  logic                flush,
   input  logic [TAG_BITS-1:0] flush_tag,
   output logic [TAG_BITS-1:0] head,
   output logic [TAG_BITS-1:0] tail,
   output logic [TAG_BITS:0]   count
);

   localparam int CW = TAG_BITS + 1;

   logic [TAG_BITS-1:0] head_reg, head_next;
   logic [TAG_BITS-1:0] tail_reg, tail_next;
   logic [CW-1:0]       count_reg, count_next;
   logic [TAG_BITS-1:0] tag_age;

   assign tag_age = flush_tag - head_reg;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (retire)
         head_next = head_reg + TAG_BITS'(1);
      // A flush keeps everything from head up to and including the flushing tag.
      if (flush) begin
         tail_next  = flush_tag + TAG_BITS'(1);
         count_next = CW'(tag_age) + CW'(1) - CW'(retire);
      end else begin
         if (alloc)
            tail_next = tail_reg + TAG_BITS'(1);
         count_next = count_reg + CW'(alloc) - CW'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign head  = head_reg;
   assign tail  = tail_reg;
   assign count = count_reg;

endmodule

// File: rtl/branch_inflight_tracker.sv
// Holds predicted branches from fetch to retirement, raises recovery on mispredicts, trains in order.
module branch_inflight_tracker
   import bp_pkg::*;
#(
   parameter  int GH       = GH_DEFAULT,
   parameter  int DEPTH    = 8,
   localparam int TAG_BITS = $clog2(DEPTH)
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                alloc_valid_i,
   input  logic [31:0]         alloc_pc_i,
   input  logic                alloc_pred_taken_i,
   input  logic [31:0]         alloc_pred_target_i,
   input  logic [GH-1:0]       alloc_ghr_snapshot_i,
   output logic                alloc_ready_o,
   output logic [TAG_BITS-1:0] alloc_tag_o,
   input  logic                resolve_valid_i,
   input  logic [TAG_BITS-1:0] resolve_tag_i,
   input  logic                resolve_taken_i,
   input  logic [31:0]         resolve_target_i,
   output logic                recover_mispredict_pulse_o,
   output logic [GH-1:0]       recover_ghr_snapshot_o,
   output logic [31:0]         recover_pc_o,
   output logic                train_valid_o,
   output logic [31:0]         train_pc_o,
   output logic                train_actual_taken_o,
   output logic [31:0]         train_actual_target_o,
   output logic [GH-1:0]       train_ghr_snapshot_o,
   output logic [TAG_BITS:0]   count_o
);

   inflight_entry_t     entry_reg [DEPTH];
   logic [GH-1:0]       snap_reg  [DEPTH];

   logic [TAG_BITS-1:0] head, tail;
   logic [TAG_BITS:0]   count;
   inflight_entry_t     head_entry, sel_entry;
   logic                retire, alloc_fire, resolve_accept, mispredict_now;
   logic [TAG_BITS-1:0] tag_age;
   logic [DEPTH-1:0]    flush_vec;

   assign head_entry = entry_reg[head];
   assign sel_entry  = entry_reg[resolve_tag_i];

   assign retire         = head_entry.valid && head_entry.resolved;
   assign resolve_accept = resolve_valid_i && sel_entry.valid && !sel_entry.resolved
                           && !sel_entry.mispredicted;
   assign mispredict_now = resolve_accept &&
                           ((resolve_taken_i != sel_entry.pred_taken) ||
                            (resolve_taken_i && (resolve_target_i != sel_entry.pred_target)));

   assign alloc_ready_o = (count != (TAG_BITS+1)'(DEPTH)) && !mispredict_now;
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign alloc_tag_o   = tail;
   assign count_o       = count;

   // Age is distance from head, so "younger than the tag" is a plain unsigned compare.
   assign tag_age = resolve_tag_i - head;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flush
         logic [TAG_BITS-1:0] age;
         assign age           = TAG_BITS'(gi) - head;
         assign flush_vec[gi] = mispredict_now && entry_reg[gi].valid && (age > tag_age);
      end
   endgenerate

   inflight_ring_ptr #(.DEPTH(DEPTH)) u_ring_ptr (
      .clk       (clock_i),
      .srst      (reset_i),
      .alloc     (alloc_fire),
      .retire    (retire),
      .flush     (mispredict_now),
      .flush_tag (resolve_tag_i),
      .head      (head),
      .tail      (tail),
      .count     (count)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++)
            entry_reg[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush_vec[i] || (retire && (head == TAG_BITS'(i))))
               entry_reg[i].valid <= 1'b0;
         end
         if (alloc_fire) begin
            entry_reg[tail] <= '{valid: 1'b1, resolved: 1'b0, mispredicted: 1'b0,
                                 pc: alloc_pc_i, pred_taken: alloc_pred_taken_i,
                                 pred_target: alloc_pred_target_i,
                                 act_taken: 1'b0, act_target: 32'd0};
            snap_reg[tail]  <= alloc_ghr_snapshot_i;
         end
         if (resolve_accept) begin
            entry_reg[resolve_tag_i].resolved     <= 1'b1;
            entry_reg[resolve_tag_i].mispredicted <= mispredict_now;
            entry_reg[resolve_tag_i].act_taken    <= resolve_taken_i;
            entry_reg[resolve_tag_i].act_target   <= resolve_target_i;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         recover_mispredict_pulse_o <= 1'b0;
         recover_ghr_snapshot_o     <= '0;
         recover_pc_o               <= '0;
         train_valid_o              <= 1'b0;
         train_pc_o                 <= '0;
         train_actual_taken_o       <= 1'b0;
         train_actual_target_o      <= '0;
         train_ghr_snapshot_o       <= '0;
      end else begin
         recover_mispredict_pulse_o <= mispredict_now;
         if (mispredict_now) begin
            recover_ghr_snapshot_o <= GH'(ghr_push(GHR_MAX'(snap_reg[resolve_tag_i]),
                                                   resolve_taken_i));
            recover_pc_o           <= resolve_taken_i ? resolve_target_i
                                                      : sel_entry.pc + 32'd4;
         end
         train_valid_o <= retire;
         if (retire) begin
            train_pc_o            <= head_entry.pc;
            train_actual_taken_o  <= head_entry.act_taken;
            train_actual_target_o <= head_entry.act_target;
            train_ghr_snapshot_o  <= snap_reg[head];
         end
      end
   end

endmodule

// File: tb/tb_branch_inflight_tracker.sv
// Directed bench for branch_inflight_tracker with hand-computed expectations.
module tb_branch_inflight_tracker;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        alloc_valid_i = 1'b0;
   logic [31:0] alloc_pc_i = '0;
   logic        alloc_pred_taken_i = 1'b0;
   logic [31:0] alloc_pred_target_i = '0;
   logic [3:0]  alloc_ghr_snapshot_i = '0;
   logic        alloc_ready_o;
   logic [2:0]  alloc_tag_o;
   logic        resolve_valid_i = 1'b0;
   logic [2:0]  resolve_tag_i = '0;
   logic        resolve_taken_i = 1'b0;
   logic [31:0] resolve_target_i = '0;
   logic        recover_mispredict_pulse_o;
   logic [3:0]  recover_ghr_snapshot_o;
   logic [31:0] recover_pc_o;
   logic        train_valid_o;
   logic [31:0] train_pc_o;
   logic        train_actual_taken_o;
   logic [31:0] train_actual_target_o;
   logic [3:0]  train_ghr_snapshot_o;
   logic [3:0]  count_o;

   int tests_run = 0;
   int tests_failed = 0;

   branch_inflight_tracker #(.GH(4), .DEPTH(8)) dut (
      .clock_i                    (clock_i),
      .reset_i                    (reset_i),
      .alloc_valid_i              (alloc_valid_i),
      .alloc_pc_i                 (alloc_pc_i),
      .alloc_pred_taken_i         (alloc_pred_taken_i),
      .alloc_pred_target_i        (alloc_pred_target_i),
      .alloc_ghr_snapshot_i       (alloc_ghr_snapshot_i),
      .alloc_ready_o              (alloc_ready_o),
      .alloc_tag_o                (alloc_tag_o),
      .resolve_valid_i            (resolve_valid_i),
      .resolve_tag_i              (resolve_tag_i),
      .resolve_taken_i            (resolve_taken_i),
      .resolve_target_i           (resolve_target_i),
      .recover_mispredict_pulse_o (recover_mispredict_pulse_o),
      .recover_ghr_snapshot_o     (recover_ghr_snapshot_o),
      .recover_pc_o               (recover_pc_o),
      .train_valid_o              (train_valid_o),
      .train_pc_o                 (train_pc_o),
      .train_actual_taken_o       (train_actual_taken_o),
      .train_actual_target_o      (train_actual_target_o),
      .train_ghr_snapshot_o       (train_ghr_snapshot_o),
      .count_o                    (count_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                        input logic [3:0] snap);
      alloc_valid_i        = 1'b1;
      alloc_pc_i           = pc;
      alloc_pred_taken_i   = pt;
      alloc_pred_target_i  = tgt;
      alloc_ghr_snapshot_i = snap;
      tick();
      alloc_valid_i        = 1'b0;
   endtask

   task automatic resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
      resolve_valid_i  = 1'b1;
      resolve_tag_i    = tag;
      resolve_taken_i  = taken;
      resolve_target_i = tgt;
      tick();
      resolve_valid_i  = 1'b0;
   endtask

   initial begin
      // Reset state and a correctly predicted not-taken branch
      do_reset();
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_ready", 64'(alloc_ready_o), 64'd1);
      check("rst_tag", 64'(alloc_tag_o), 64'd0);
      check("rst_recover", 64'(recover_mispredict_pulse_o), 64'd0);
      check("rst_train", 64'(train_valid_o), 64'd0);
      check("rst_recover_pc", 64'(recover_pc_o), 64'd0);
      alloc(32'h40, 1'b0, 32'h0, 4'b0000);
      check("t1_count_alloc", 64'(count_o), 64'd1);
      resolve(3'd0, 1'b0, 32'h0);
      check("t1_no_recover", 64'(recover_mispredict_pulse_o), 64'd0);
      check("t1_no_train_yet", 64'(train_valid_o), 64'd0);
      tick();
      check("t1_train_valid", 64'(train_valid_o), 64'd1);
      check("t1_train_pc", 64'(train_pc_o), 64'h40);
      check("t1_train_taken", 64'(train_actual_taken_o), 64'd0);
      check("t1_count_empty", 64'(count_o), 64'd0);
      tick();
      check("t1_train_pulse_end", 64'(train_valid_o), 64'd0);

      // Taken branch with wrong target
      alloc(32'h80, 1'b1, 32'h800, 4'b0101);
      resolve_valid_i  = 1'b1;
      resolve_tag_i    = 3'd1;
      resolve_taken_i  = 1'b1;
      resolve_target_i = 32'h888;
      #1;
      check("t2_ready_blocked", 64'(alloc_ready_o), 64'd0);
      tick();
      resolve_valid_i = 1'b0;
      check("t2_recover_pulse", 64'(recover_mispredict_pulse_o), 64'd1);
      check("t2_recover_pc", 64'(recover_pc_o), 64'h888);
      check("t2_recover_ghr", 64'(recover_ghr_snapshot_o), 64'b1011);
      tick();
      check("t2_pulse_end", 64'(recover_mispredict_pulse_o), 64'd0);
      check("t2_train_valid", 64'(train_valid_o), 64'd1);
      check("t2_train_target", 64'(train_actual_target_o), 64'h888);
      check("t2_train_ghr", 64'(train_ghr_snapshot_o), 64'b0101);
      check("t2_count", 64'(count_o), 64'd0);

      // Flush of younger entries
      do_reset();
      alloc(32'h0fc, 1'b0, 32'h0, 4'b0001);
      alloc(32'h100, 1'b1, 32'h200, 4'b0011);
      alloc(32'h104, 1'b0, 32'h0, 4'b0111);
      alloc(32'h108, 1'b0, 32'h0, 4'b1111);
      check("t3_count4", 64'(count_o), 64'd4);
      resolve(3'd1, 1'b0, 32'h0);
      check("t3_recover_pulse", 64'(recover_mispredict_pulse_o), 64'd1);
      check("t3_recover_pc", 64'(recover_pc_o), 64'h104);
      check("t3_recover_ghr", 64'(recover_ghr_snapshot_o), 64'b0110);
      check("t3_count_flush", 64'(count_o), 64'd2);
      check("t3_next_tag", 64'(alloc_tag_o), 64'd2);
      resolve(3'd3, 1'b1, 32'h999);
      check("t3_stale_no_pulse", 64'(recover_mispredict_pulse_o), 64'd0);
      check("t3_stale_count", 64'(count_o), 64'd2);
      check("t3_recover_pc_hold", 64'(recover_pc_o), 64'h104);

      // Full buffer and wrap
      do_reset();
      for (int i = 0; i < 8; i++)
         alloc(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 4'(i));
      check("t4_count_full", 64'(count_o), 64'd8);
      check("t4_ready_full", 64'(alloc_ready_o), 64'd0);
      check("t4_tag_wrapped", 64'(alloc_tag_o), 64'd0);
      resolve(3'd0, 1'b0, 32'h0);
      check("t4_still_full", 64'(alloc_ready_o), 64'd0);
      tick();
      check("t4_train_valid", 64'(train_valid_o), 64'd1);
      check("t4_train_pc", 64'(train_pc_o), 64'h1000);
      check("t4_count_after", 64'(count_o), 64'd7);
      check("t4_ready_after", 64'(alloc_ready_o), 64'd1);
      check("t4_tag_at_wrap", 64'(alloc_tag_o), 64'd0);
      alloc(32'h3000, 1'b0, 32'h0, 4'b0000);
      check("t4_count_refull", 64'(count_o), 64'd8);
      check("t4_tag_after_wrap", 64'(alloc_tag_o), 64'd1);

      // Out-of-order resolve, in-order training
      do_reset();
      alloc(32'h2000, 1'b0, 32'h0, 4'b0000);
      alloc(32'h2004, 1'b0, 32'h0, 4'b0000);
      alloc(32'h2008, 1'b0, 32'h0, 4'b0000);
      resolve(3'd2, 1'b0, 32'h0);
      check("t5_no_train_young", 64'(train_valid_o), 64'd0);
      resolve(3'd0, 1'b0, 32'h0);
      check("t5_no_train_yet", 64'(train_valid_o), 64'd0);
      resolve(3'd1, 1'b0, 32'h0);
      check("t5_train0_valid", 64'(train_valid_o), 64'd1);
      check("t5_train0_pc", 64'(train_pc_o), 64'h2000);
      tick();
      check("t5_train1_valid", 64'(train_valid_o), 64'd1);
      check("t5_train1_pc", 64'(train_pc_o), 64'h2004);
      tick();
      check("t5_train2_valid", 64'(train_valid_o), 64'd1);
      check("t5_train2_pc", 64'(train_pc_o), 64'h2008);
      tick();
      check("t5_train_done", 64'(train_valid_o), 64'd0);
      check("t5_count", 64'(count_o), 64'd0);

      // Reset arriving together with a mispredicting resolve
      do_reset();
      alloc(32'h400, 1'b0, 32'h0, 4'b0000);
      alloc(32'h404, 1'b1, 32'h500, 4'b0000);
      alloc(32'h408, 1'b0, 32'h0, 4'b0000);
      check("t6_count3", 64'(count_o), 64'd3);
      reset_i          = 1'b1;
      resolve_valid_i  = 1'b1;
      resolve_tag_i    = 3'd1;
      resolve_taken_i  = 1'b0;
      resolve_target_i = 32'h0;
      tick();
      reset_i         = 1'b0;
      resolve_valid_i = 1'b0;
      check("t6_rst_no_recover", 64'(recover_mispredict_pulse_o), 64'd0);
      check("t6_rst_no_train", 64'(train_valid_o), 64'd0);
      check("t6_rst_count", 64'(count_o), 64'd0);
      check("t6_rst_tag", 64'(alloc_tag_o), 64'd0);
      tick();
      check("t6_post_no_recover", 64'(recover_mispredict_pulse_o), 64'd0);
      check("t6_post_no_train", 64'(train_valid_o), 64'd0);
      check("t6_post_count", 64'(count_o), 64'd0);
      check("t6_post_tag", 64'(alloc_tag_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
